// File: rtl/hamming_rx_scheduler.sv
// Round-robin arbiter feeding one serial Hamming(7,4) decoder from two lanes.
// Shifts the granted codeword LSB-first, waits for the result or a timeout.
module hamming_rx_scheduler #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [6:0] cw0,
    input  logic [6:0] cw1,
    output logic [1:0] ack,
    output logic [1:0] rsp_valid,
    output logic [3:0] rsp_data,
    output logic       rsp_err,
    output logic       busy,
    output logic       dec_ena,
    output logic       dec_bit,
    output logic       dec_flush,
    input  logic       dec_valid,
    input  logic [3:0] dec_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_DECODE,
        S_WAIT,
        S_RESP
    } state_e;

    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    state_e     state_q;
    logic [6:0] cw_q;
    logic [2:0] idx_q;
    logic [7:0] timer_q;
    logic       g_q;
    logic       last_q;
    logic [3:0] data_q;
    logic       err_q;
    logic [1:0] ack_q;
    logic [1:0] rsp_valid_q;
    logic       busy_q;
    logic       dec_ena_q;
    logic       dec_bit_q;

    logic       gnt_d;
    logic [6:0] cw_d;
    logic [2:0] idx_d;

    // Round-robin lane choice: contested requests go to the lane not served last.
    always_comb begin
        gnt_d = 1'b0;
        if (req == 2'b11) begin
            gnt_d = ~last_q;
        end else begin
            gnt_d = req[1];
        end
        cw_d  = gnt_d ? cw1 : cw0;
        idx_d = idx_q + 3'd1;
    end

    // Transaction sequencer; every output is a register set on the edge entering its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cw_q        <= '0;
            idx_q       <= '0;
            timer_q     <= '0;
            g_q         <= 1'b0;
            last_q      <= 1'b1;
            data_q      <= '0;
            err_q       <= 1'b0;
            ack_q       <= '0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            dec_ena_q   <= 1'b0;
            dec_bit_q   <= 1'b0;
        end else begin
            ack_q       <= '0;
            rsp_valid_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        cw_q      <= cw_d;
                        g_q       <= gnt_d;
                        last_q    <= gnt_d;
                        idx_q     <= '0;
                        ack_q     <= gnt_d ? 2'b10 : 2'b01;
                        busy_q    <= 1'b1;
                        dec_ena_q <= 1'b1;
                        dec_bit_q <= cw_d[0];
                        state_q   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (idx_q == 3'd6) begin
                        dec_bit_q <= 1'b0;
                        state_q   <= S_DECODE;
                    end else begin
                        idx_q     <= idx_d;
                        dec_bit_q <= cw_q[idx_d];
                    end
                end
                S_DECODE: begin
                    timer_q   <= '0;
                    dec_ena_q <= 1'b0;
                    dec_bit_q <= 1'b0;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    if (dec_valid) begin
                        data_q      <= dec_data;
                        err_q       <= 1'b0;
                        rsp_valid_q <= g_q ? 2'b10 : 2'b01;
                        state_q     <= S_RESP;
                    end else if (timer_q == TMAX) begin
                        data_q      <= '0;
                        err_q       <= 1'b1;
                        rsp_valid_q <= g_q ? 2'b10 : 2'b01;
                        state_q     <= S_RESP;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                S_RESP: begin
                    data_q  <= '0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack       = ack_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
    assign dec_flush = err_q;
    assign busy      = busy_q;
    assign dec_ena   = dec_ena_q;
    assign dec_bit   = dec_bit_q;

endmodule

// File: tb/tb_hamming_rx_scheduler.sv
// Directed bench for hamming_rx_scheduler: arbitration, shift order,
// decoder handshake, timeout, reset abort and back-to-back service.
module tb_hamming_rx_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [6:0] cw0;
    logic [6:0] cw1;
    logic [1:0] ack;
    logic [1:0] rsp_valid;
    logic [3:0] rsp_data;
    logic       rsp_err;
    logic       busy;
    logic       dec_ena;
    logic       dec_bit;
    logic       dec_flush;
    logic       dec_valid;
    logic [3:0] dec_data;

    int checks = 0;
    int errors = 0;

    hamming_rx_scheduler #(.TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .cw0       (cw0),
        .cw1       (cw1),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .dec_ena   (dec_ena),
        .dec_bit   (dec_bit),
        .dec_flush (dec_flush),
        .dec_valid (dec_valid),
        .dec_data  (dec_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance into the next cycle, 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ack"}, {6'd0, ack}, 8'd0);
        chk({tag, "_rspv"}, {6'd0, rsp_valid}, 8'd0);
        chk({tag, "_outs"},
            {rsp_data, rsp_err, busy, dec_ena, dec_bit}, 8'd0);
        chk({tag, "_flush"}, {7'd0, dec_flush}, 8'd0);
    endtask

    // Entered in the IDLE cycle (cycle 0). k<0: decoder stays silent.
    // pulse: a stray dec_valid in cycle 3 (SHIFT), which must be ignored.
    task automatic txn(input string tag, input logic [1:0] r,
                       input logic [1:0] lane, input int k,
                       input logic [3:0] d, input logic drop,
                       input logic pulse);
        req = r;
        step();
        chk({tag, "_ack"}, {6'd0, ack}, {6'd0, lane});
        chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
        if (drop) req = 2'b00;
        for (int i = 2; i <= 8; i++) begin
            step();
            if (pulse && i == 3) begin
                dec_valid = 1'b1;
                dec_data  = 4'h7;
            end else begin
                dec_valid = 1'b0;
            end
        end
        chk({tag, "_c8"}, {6'd0, dec_ena, dec_bit}, 8'h2);
        step();
        chk({tag, "_c9"}, {3'd0, dec_ena, rsp_data}, 8'h0);
        if (k < 0) begin
            for (int i = 0; i < 15; i++) step();
        end else begin
            for (int i = 0; i < k; i++) step();
            dec_valid = 1'b1;
            dec_data  = d;
            step();
            dec_valid = 1'b0;
        end
        chk({tag, "_rspv"}, {6'd0, rsp_valid}, {6'd0, lane});
        chk({tag, "_data"}, {4'd0, rsp_data}, (k < 0) ? 8'h0 : {4'd0, d});
        chk({tag, "_err"}, {6'd0, rsp_err, dec_flush},
            (k < 0) ? 8'h3 : 8'h0);
        step();
        chk({tag, "_idle"}, {5'd0, busy, rsp_valid}, 8'h0);
    endtask

    initial begin
        rst       = 1'b1;
        req       = 2'b00;
        cw0       = 7'b1010101;
        cw1       = 7'b1100011;
        dec_valid = 1'b0;
        dec_data  = 4'h0;
        step();
        step();
        chk_quiet("rst");
        rst = 1'b0;
        step();

        // Lane 0 alone, bit-by-bit shift check.
        req = 2'b01;
        step();
        chk("t1_ack", {6'd0, ack}, 8'h01);
        chk("t1_bit0", {6'd0, dec_ena, dec_bit}, 8'h3);
        req = 2'b00;
        for (int i = 1; i < 7; i++) begin
            step();
            chk($sformatf("t1_bit%0d", i), {6'd0, dec_ena, dec_bit},
                {6'd0, 1'b1, ~i[0]});
            chk($sformatf("t1_ack%0d", i), {6'd0, ack}, 8'h0);
        end
        step();
        chk("t1_c8", {6'd0, dec_ena, dec_bit}, 8'h2);
        step();
        chk("t1_c9", {6'd0, dec_ena, busy}, 8'h1);
        dec_valid = 1'b1;
        dec_data  = 4'hB;
        step();
        dec_valid = 1'b0;
        chk("t1_rspv", {6'd0, rsp_valid}, 8'h01);
        chk("t1_data", {4'd0, rsp_data}, 8'h0B);
        chk("t1_err", {6'd0, rsp_err, dec_flush}, 8'h0);
        step();
        chk_quiet("t1_after");

        // Both lanes from reset: order 0,1,0,1.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        txn("rr0", 2'b11, 2'b01, 0, 4'h1, 1'b0, 1'b0);
        txn("rr1", 2'b11, 2'b10, 2, 4'h2, 1'b0, 1'b0);
        txn("rr2", 2'b11, 2'b01, 1, 4'hC, 1'b0, 1'b0);
        txn("rr3", 2'b11, 2'b10, 0, 4'h5, 1'b1, 1'b0);
        step();

        // Silent decoder: timeout response in cycle 24.
        txn("tmo", 2'b01, 2'b01, -1, 4'h0, 1'b1, 1'b0);

        // Valid in the last WAIT cycle wins over expiry; SHIFT pulse ignored.
        txn("late", 2'b10, 2'b10, 14, 4'h9, 1'b1, 1'b1);

        // Reset in cycle 5 aborts; contested grant then goes to lane 0.
        req = 2'b01;
        step();
        req = 2'b00;
        for (int i = 2; i <= 5; i++) step();
        chk("ab_busy", {7'd0, busy}, 8'd1);
        rst = 1'b1;
        #1;
        chk_quiet("ab_now");
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("ab_q%0d", i), {5'd0, busy, rsp_valid}, 8'h0);
        end
        txn("ab_rr", 2'b11, 2'b01, 0, 4'hE, 1'b1, 1'b0);

        // Lane 1 keeps req high: served again, ack in cycle 12.
        txn("hold0", 2'b10, 2'b10, 0, 4'h3, 1'b0, 1'b0);
        txn("hold1", 2'b10, 2'b10, 0, 4'h6, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
